// File: rtl/seq_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter_if
// Description : Handshake/data bundle between a requester and seq_shifter.
//               master modport = requester side, slave modport = shifter.
// Ports       : i_start  - request a shift (requester -> shifter)
//               i_val    - operand
//               i_amount - shift distance in bit positions
//               i_dir    - 0 = left, 1 = right
//               i_arith  - 1 = arithmetic right shift (sign fill)
//               o_val    - working/result register
//               o_busy   - shifter not idle
//               o_done   - one-cycle completion pulse
//               o_lost   - sticky OR of shifted-out bits
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_shifter_if #(
  parameter int DW = 32,
  parameter int AW = 6
) ();

  logic          i_start;
  logic [DW-1:0] i_val;
  logic [AW-1:0] i_amount;
  logic          i_dir;
  logic          i_arith;
  logic [DW-1:0] o_val;
  logic          o_busy;
  logic          o_done;
  logic          o_lost;

  modport master (
    output i_start, i_val, i_amount, i_dir, i_arith,
    input  o_val, o_busy, o_done, o_lost
  );

  modport slave (
    input  i_start, i_val, i_amount, i_dir, i_arith,
    output o_val, o_busy, o_done, o_lost
  );

endinterface : seq_shifter_if
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Multi-cycle variable-amount shifter. Captures an operand on an
//               accepted start, then shifts it one bit position per clock
//               (left, logical right or arithmetic right) for min(amount, DW)
//               cycles, flagging any one bits shifted out.
// Ports       : clk - system clock, rising edge
//               rst - asynchronous active-low reset
//               bus - seq_shifter_if.slave (start/operand in, result/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  wire logic    clk,
  input  wire logic    rst,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // DW expressed in the amount width; AW is sized so this cannot truncate.
  localparam logic [AW-1:0] C_DW_AMT = AW'(DW);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_val;
  logic          r_lost;
  logic [AW-1:0] r_count;
  logic          r_dir;
  logic          r_arith;

  logic [AW-1:0] w_count_load;
  logic          w_fill;
  logic          w_out_bit;
  logic [DW-1:0] w_shift_val;
  logic          w_accept;

  // Distances beyond the width are clamped: the extra shifts would only
  // repeat the fill value and can lose no further bits.
  assign w_count_load = (bus.i_amount > C_DW_AMT) ? C_DW_AMT : bus.i_amount;

  assign w_accept = (r_state == S_IDLE) && bus.i_start;

  // Sign fill only for arithmetic right shifts; left shifts ignore r_arith.
  assign w_fill      = r_arith & r_val[DW-1];
  assign w_out_bit   = r_dir ? r_val[0] : r_val[DW-1];
  assign w_shift_val = r_dir ? {w_fill, r_val[DW-1:1]}
                             : {r_val[DW-2:0], 1'b0};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = (w_count_load == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Leave on the edge that performs the final shift (count 1 -> 0).
        if (r_count == AW'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: capture on accepted start, shift once per cycle in SHIFT.
  // Result and lost flag hold in DONE/IDLE until the next accepted start.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val   <= '0;
      r_lost  <= 1'b0;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_arith <= 1'b0;
    end else if (w_accept) begin
      r_val   <= bus.i_val;
      r_lost  <= 1'b0;
      r_count <= w_count_load;
      r_dir   <= bus.i_dir;
      r_arith <= bus.i_arith;
    end else if (r_state == S_SHIFT) begin
      r_val   <= w_shift_val;
      r_lost  <= r_lost | w_out_bit;
      r_count <= r_count - AW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registers or decodes of registered state only.
  // --------------------------------------------------------------------------
  assign bus.o_val  = r_val;
  assign bus.o_lost = r_lost;
  assign bus.o_busy = (r_state != S_IDLE);
  assign bus.o_done = (r_state == S_DONE);

endmodule : seq_shifter
`default_nettype wire
